serial_word_shifter: RTL

//  - Upstream feeder for the serial sequence detector.
//  - Accepts parallel words over a valid/ready handshake.
//  - Shifts each word out one bit per clock on SER_OUT, which drives the detector's IN.
//  - Back-to-back words stream with no gap bit, so patterns that span a word boundary remain detectable.

---
 rtl/serial_pkg.sv | 24 ++
 rtl/serial_word_shifter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial word shifter.
// The state encoding is fixed so that PARITY keeps its code even in builds
// where the SERIAL_PARITY_EN feature is compiled out.
package serial_pkg;

  // Frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10
  } state_e;

  // Default word width and the level driven on the serial line between words
  localparam int   DEFAULT_WIDTH    = 8;
  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // Bit counter width for a given word width: enough to hold 0..width
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage : serial_pkg

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial word shifter feeding the serial sequence detector.
// Words arrive over a valid/ready handshake and leave one bit per clock on
// SER_OUT. A word accepted on the last bit of the previous frame streams on
// with no gap bit, so patterns spanning a word boundary stay contiguous.
//
// Build option: define SERIAL_PARITY_EN to append one even-parity bit per
// frame (frame length WIDTH+1); FRAME_END and DIN_READY then move to that
// parity cycle. Left undefined, frames are exactly WIDTH bits.
module serial_word_shifter
  import serial_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SER_OUT,
  output logic             SER_VALID,
  output logic             BUSY,
  output logic             FRAME_END
);

  localparam int                  CNT_BITS = cnt_width(WIDTH);
  // cnt value while the final data bit sits on SER_OUT
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);
  // cnt value one bit before that
  localparam logic [CNT_BITS-1:0] PREV_CNT = CNT_BITS'(WIDTH - 2);

  // cnt_q is the index (in send order) of the bit currently on SER_OUT;
  // shreg_q is pre-shifted so the following bit is always at a fixed tap.
  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic                ser_out_q, ser_out_d;
  logic                ser_valid_q, ser_valid_d;
  logic                frame_end_q, frame_end_d;
`ifdef SERIAL_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic             din_ready;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // Bit-order selection: first bit of an incoming word, and the shift
  // direction / tap that yields the following bit of the word in flight.
  assign first_bit     = MSB_FIRST ? DIN[WIDTH-1]     : DIN[0];
  assign next_bit      = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  // Ready whenever idle or on the final bit of a frame (back-to-back reload)
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    din_ready = 1'b0;
    case (state_q)
      ST_IDLE: din_ready = 1'b1;
`ifdef SERIAL_PARITY_EN
      ST_SHIFT:  din_ready = 1'b0;
      ST_PARITY: din_ready = 1'b1;
`else
      ST_SHIFT:  din_ready = (cnt_q == LAST_CNT);
`endif
      default: din_ready = 1'b0;
    endcase
  end

  assign accept = DIN_VALID & din_ready;

  // Next-state and next-output computation for the frame sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ser_out_d   = IDLE_BIT;
    ser_valid_d = 1'b0;
    frame_end_d = 1'b0;
`ifdef SERIAL_PARITY_EN
    parity_d    = parity_q;
`endif

    if (accept) begin
      // Load a fresh word; its first bit goes out in the very next cycle.
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      shreg_d     = DIN;
      ser_out_d   = first_bit;
      ser_valid_d = 1'b1;
`ifdef SERIAL_PARITY_EN
      parity_d    = ^DIN;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
        end

        ST_SHIFT: begin
          if (cnt_q != LAST_CNT) begin
            cnt_d       = cnt_q + CNT_BITS'(1);
            shreg_d     = shreg_shifted;
            ser_out_d   = next_bit;
            ser_valid_d = 1'b1;
`ifdef SERIAL_PARITY_EN
            frame_end_d = 1'b0;
`else
            frame_end_d = (cnt_q == PREV_CNT);
`endif
          end else begin
`ifdef SERIAL_PARITY_EN
            // Data bits done: append the parity bit, which closes the frame.
            state_d     = ST_PARITY;
            ser_out_d   = parity_q;
            ser_valid_d = 1'b1;
            frame_end_d = 1'b1;
`else
            // Frame finished with nothing waiting: return the line to idle.
            state_d = ST_IDLE;
            cnt_d   = '0;
`endif
          end
        end

`ifdef SERIAL_PARITY_EN
        ST_PARITY: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
`endif

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and registered outputs; async reset discards any word in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      frame_end_q <= frame_end_d;
`ifdef SERIAL_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign DIN_READY = din_ready;
  assign SER_OUT   = ser_out_q;
  assign SER_VALID = ser_valid_q;
  assign FRAME_END = frame_end_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule : serial_word_shifter
